multicycle_controller: RTL and testbench

- Control unit for the RV32 multicycle datapath, directly upstream of the ALU.
- Contains a Moore main FSM that sequences fetch, decode, execute, memory and writeback.
- Contains a combinational ALU decoder that drives the ALU's 3-bit ALUControl.
- Generates PCWrite from the ALU Zero flag for beq.

---
 rtl/multicycle_controller.sv | 179 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control unit for the RV32 multicycle datapath. A Moore main FSM sequences
//   fetch/decode/execute/memory/writeback; a combinational ALU decoder drives
//   ALUControl; PCWrite combines the unconditional PC update with beq + Zero.
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5 - instruction fields [6:0], [14:12], [30]
//   Zero                 - ALU zero flag (same-cycle effect on PCWrite)
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, RegWrite - datapath controls
//   IllegalOp            - pulses in DECODE for an unsupported opcode
//   Halted               - high while parked in HALT (ILLEGAL_TRAP=1 only)
module multicycle_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic       Halted
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT
    } state_t;

    state_t state, state_next, ostate;

    logic       supported;
    logic       pcupdate, branch, memw, irw, regw, halt_st;
    logic [1:0] aluop;

    assign supported = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                       (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = ILLEGAL_TRAP ? HALT : FETCH;
                endcase
            end
            MEMADR:   state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = FETCH;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BEQ:      state_next = FETCH;
            JAL:      state_next = ALUWB;
            HALT:     state_next = HALT;
            default:  state_next = FETCH;
        endcase
    end

    // Outputs are decoded from FETCH while reset is high so the selects show
    // the FETCH encoding; the write strobes are then masked separately below.
    assign ostate = reset ? FETCH : state;

    always_comb begin
        pcupdate  = 1'b0;
        branch    = 1'b0;
        memw      = 1'b0;
        irw       = 1'b0;
        regw      = 1'b0;
        halt_st   = 1'b0;
        aluop     = 2'b00;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (ostate)
            FETCH: begin
                irw       = 1'b1;
                pcupdate  = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB:    regw = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
            end
            HALT:     halt_st = 1'b1;
            default: ;
        endcase
    end

    assign PCWrite   = ~reset & (pcupdate | (branch & Zero));
    assign IRWrite   = ~reset & irw;
    assign RegWrite  = ~reset & regw;
    assign MemWrite  = ~reset & memw;
    assign Halted    = ~reset & halt_st;
    assign IllegalOp = ~reset & (state == DECODE) & ~supported;

    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed-vector bench. Two instances share all inputs: u_nop
//   (ILLEGAL_TRAP=0) and u_trap (ILLEGAL_TRAP=1). Outputs are packed into a
//   16-bit word {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,
//   ALUControl,RegWrite,IllegalOp,Halted} and compared with hand-built words.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       pcw0, adr0, mw0, irw0, rw0, ill0, hlt0;
    logic [1:0] res0, sa0, sb0;
    logic [2:0] alu0;
    logic       pcw1, adr1, mw1, irw1, rw1, ill1, hlt1;
    logic [1:0] res1, sa1, sb1;
    logic [2:0] alu1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ILLEGAL_TRAP(1'b0)) u_nop (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0),
        .ResultSrc(res0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0),
        .RegWrite(rw0), .IllegalOp(ill0), .Halted(hlt0)
    );

    multicycle_controller #(.ILLEGAL_TRAP(1'b1)) u_trap (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1),
        .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1),
        .RegWrite(rw1), .IllegalOp(ill1), .Halted(hlt1)
    );

    logic [15:0] sig0, sig1;
    assign sig0 = {pcw0, adr0, mw0, irw0, res0, sa0, sb0, alu0, rw0, ill0, hlt0};
    assign sig1 = {pcw1, adr1, mw1, irw1, res1, sa1, sb1, alu1, rw1, ill1, hlt1};

    function automatic logic [15:0] mk(input logic pcw, adr, memw, irw,
                                       input logic [1:0] res, srca, srcb,
                                       input logic [2:0] alu,
                                       input logic regw, ill, halt);
        return {pcw, adr, memw, irw, res, srca, srcb, alu, regw, ill, halt};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Check both instances #1 after the current negedge, then advance one cycle.
    task automatic cyc(input string tag, input logic [15:0] exp);
        #1;
        check({tag, "/nop"}, sig0, exp);
        check({tag, "/trap"}, sig1, exp);
        @(negedge clk);
    endtask

    task automatic set_ins(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    endtask

    logic [15:0] S_F, S_RST, S_D, S_DI, S_MA, S_MR, S_MWB, S_MW, S_AWB, S_J, S_H;

    initial begin
        S_F   = mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,0,0);
        S_RST = mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0,0);
        S_D   = mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0,0);
        S_DI  = mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,1,0);
        S_MA  = mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0);
        S_MR  = mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0);
        S_MWB = mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,1,0,0);
        S_MW  = mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,0,0);
        S_AWB = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0,0);
        S_J   = mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,0,0,0);
        S_H   = mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,1);

        reset = 1'b1;
        set_ins(7'b0110011, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        cyc("rst0", S_RST);
        cyc("rst1", S_RST);
        reset = 1'b0;

        // lw: 5 cycles then FETCH
        set_ins(7'b0000011, 3'b010, 1'b0, 1'b0);
        cyc("lw_fetch", S_F);
        cyc("lw_dec", S_D);
        cyc("lw_madr", S_MA);
        cyc("lw_mrd", S_MR);
        cyc("lw_mwb", S_MWB);

        // R-type sub + funct3 sweep
        set_ins(7'b0110011, 3'b000, 1'b1, 1'b0);
        cyc("sub_fetch", S_F);
        cyc("sub_dec", S_D);
        cyc("sub_exe", mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,0));
        cyc("sub_wb", S_AWB);
        for (int unsigned i = 0; i < 3; i++) begin
            logic [2:0] f3v, aluv;
            f3v  = (i == 0) ? 3'b010 : (i == 1) ? 3'b110 : 3'b111;
            aluv = (i == 0) ? 3'b101 : (i == 1) ? 3'b011 : 3'b010;
            set_ins(7'b0110011, f3v, 1'b0, 1'b0);
            cyc("r_fetch", S_F);
            cyc("r_dec", S_D);
            cyc("r_exe", mk(0,0,0,0,2'b00,2'b10,2'b00,aluv,0,0,0));
            cyc("r_wb", S_AWB);
        end

        // addi with funct7b5=1 must still add
        set_ins(7'b0010011, 3'b000, 1'b1, 1'b0);
        cyc("addi_fetch", S_F);
        cyc("addi_dec", S_D);
        cyc("addi_exe", mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0));
        cyc("addi_wb", S_AWB);

        // beq taken / not taken; Zero must not leak into DECODE
        set_ins(7'b1100011, 3'b000, 1'b0, 1'b1);
        cyc("beqt_fetch", S_F);
        cyc("beqt_dec", S_D);
        cyc("beqt_br", mk(1,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,0));
        set_ins(7'b1100011, 3'b000, 1'b0, 1'b0);
        cyc("beqn_fetch", S_F);
        cyc("beqn_dec", S_D);
        cyc("beqn_br", mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,0));

        // jal
        set_ins(7'b1101111, 3'b000, 1'b0, 1'b0);
        cyc("jal_fetch", S_F);
        cyc("jal_dec", S_D);
        cyc("jal_jal", S_J);
        cyc("jal_wb", S_AWB);

        // sw: MemWrite exactly once, no RegWrite
        set_ins(7'b0100011, 3'b010, 1'b0, 1'b0);
        cyc("sw_fetch", S_F);
        cyc("sw_dec", S_D);
        cyc("sw_madr", S_MA);
        cyc("sw_mw", S_MW);
        cyc("sw_next", S_F);
        cyc("sw2_dec", S_D);
        cyc("sw2_madr", S_MA);

        // reset asserted in MEMWRITE
        #1;
        check("pre_rst_mw", sig0, S_MW);
        reset = 1'b1;
        cyc("rst_in_mw", S_RST);
        reset = 1'b0;
        cyc("after_rst_mw", S_F);

        // unsupported opcode
        set_ins(7'b1111111, 3'b000, 1'b0, 1'b0);
        cyc("ill_dec", S_DI);
        set_ins(7'b0110011, 3'b000, 1'b0, 1'b0);
        #1;
        check("ill_nop_fetch", sig0, S_F);
        check("ill_trap_halt", sig1, S_H);
        @(negedge clk);
        for (int unsigned i = 0; i < 10; i++) begin
            #1;
            check("halt_hold", sig1, S_H);
            @(negedge clk);
        end

        // reset asserted in HALT
        reset = 1'b1;
        #1;
        check("rst_in_halt", sig1, S_RST);
        @(negedge clk);
        reset = 1'b0;
        cyc("after_rst_halt", S_F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
